spi_mode_arbiter: RTL and testbench

Shares one SPI generator (the block driving MOSI/SCK/CS with selectable CKP/CPH) between NREQ requesters, each with its own SPI mode and transmit byte. Grants are round-robin. For each granted transaction the block loads the winner's CKP/CPH into the generator, waits a settle interval, pulses start, waits for the generator's done, returns the received byte and pulses that requester's done. It sits between the client logic and the SPI generator.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_mode_arbiter_rr_pick.sv | 41 ++++
 rtl/spi_mode_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_spi_mode_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode arbiter: arbiter state encoding,
// SPI mode constants and default widths.
package spi_pkg;

  localparam int unsigned SPI_NREQ_DEF    = 2;
  localparam int unsigned SPI_DW_DEF      = 8;
  localparam int unsigned SPI_SETUP_DEF   = 4;
  localparam int unsigned SPI_TIMEOUT_DEF = 1024;

  // SPI modes as {CKP,CPH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_SETUP = 3'd1,
    ARB_START = 3'd2,
    ARB_WAIT  = 3'd3,
    ARB_DONE  = 3'd4
  } arb_state_t;

  // Round-robin successor of idx among n requesters
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/spi_mode_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first requester
// at or after ptr_i (wrapping) whose request is high, as one-hot and index.
module rr_pick #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]                         req_i,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
  output logic [NREQ-1:0]                         gnt_oh_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_idx_o,
  output logic                                    any_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0] cand_s;

  // Scan upward from the pointer with wrap; the first active requester wins
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, ptr_i} + CW'(k);
      if (cand_s >= CW'(NREQ)) begin
        cand_s = cand_s - CW'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!any_o && req_i[cand_s[PW-1:0]]) begin
        any_o                     = 1'b1;
        gnt_idx_o                 = cand_s[PW-1:0];
        gnt_oh_o[cand_s[PW-1:0]]  = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/spi_mode_arbiter.sv
// spi_mode_arbiter: shares one SPI generator between NREQ requesters.
// Round-robin grant, loads the winner's CKP/CPH and tx word, holds them for
// SETUP_CYC cycles so SCK settles at its idle level, pulses start, waits for
// the generator's done and returns the received word.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a WAIT lasting
// TIMEOUT cycles (rx_o = all ones, sticky err).
module spi_mode_arbiter import spi_pkg::*; #(
  parameter int unsigned NREQ      = SPI_NREQ_DEF,
  parameter int unsigned DW        = SPI_DW_DEF,
  parameter int unsigned SETUP_CYC = SPI_SETUP_DEF,
  parameter int unsigned TIMEOUT   = SPI_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    mode_i,
  input  logic [DW*NREQ-1:0]   tx_i,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rx_o,
  output logic                 busy,
  output logic                 err,
  output logic                 spi_ckp,
  output logic                 spi_cph,
  output logic [DW-1:0]        spi_tx,
  output logic                 spi_start,
  input  logic                 spi_done,
  input  logic [DW-1:0]        spi_rx
);

  localparam int unsigned PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_MAX = (SETUP_CYC > TIMEOUT) ? SETUP_CYC : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DW-1:0]     rx_q, rx_d;
  logic              busy_q, busy_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic [DW-1:0]     tx_q, tx_d;
  logic              start_q, start_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  logic [NREQ-1:0]   pick_oh_s;
  logic [PW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [1:0]        pick_mode_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh_s),
    .gnt_idx_o (pick_idx_s),
    .any_o     (pick_any_s)
  );

  assign pick_mode_s = mode_i[{pick_idx_s, 1'b0} +: 2];

  // Next-state and next-output logic of the arbiter FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rx_d    = rx_q;
    ckp_d   = ckp_q;
    cph_d   = cph_q;
    tx_d    = tx_q;
    start_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_d = ARB_SETUP;
          gnt_d   = pick_oh_s;
          gidx_d  = pick_idx_s;
          ckp_d   = pick_mode_s[1];
          cph_d   = pick_mode_s[0];
          tx_d    = tx_i[DW*int'(pick_idx_s) +: DW];
          cnt_d   = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = ARB_START;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ARB_START: begin
        state_d = ARB_WAIT;
        cnt_d   = '0;
      end
      ARB_WAIT: begin
        if (spi_done) begin
          state_d = ARB_DONE;
          rx_d    = spi_rx;
          done_d  = gnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Generator never answered: complete with an all-ones word
          state_d = ARB_DONE;
          rx_d    = '1;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        end else begin
          state_d = ARB_WAIT;
        end
`endif
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        ptr_d   = PW'(rr_next(32'(gidx_q), NREQ));
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and registered outputs; reset forces the generator to idle mode 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      ckp_q   <= MODE0[1];
      cph_q   <= MODE0[0];
      tx_q    <= '0;
      start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      ckp_q   <= ckp_d;
      cph_q   <= cph_d;
      tx_q    <= tx_d;
      start_q <= start_d;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rx_o      = rx_q;
  assign busy      = busy_q;
  assign spi_ckp   = ckp_q;
  assign spi_cph   = cph_q;
  assign spi_tx    = tx_q;
  assign spi_start = start_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mode_arbiter.sv
// Randomized bench for spi_mode_arbiter. A driver owns a transaction-level
// model (requester states, round-robin pointer, cycle timeline) and pushes
// each predicted transaction into a scoreboard queue; a monitor compares the
// DUT outputs every cycle against the queue head and pops on completion.
module tb_spi_mode_arbiter;

  localparam int NREQ    = 3;
  localparam int DW      = 8;
  localparam int SETUP   = 4;
  localparam int TMO     = 16;
  localparam int RUN_CYC = 4000;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [2*NREQ-1:0]   mode_i = '0;
  logic [DW*NREQ-1:0]  tx_i = '0;
  logic                spi_done = 1'b0;
  logic [DW-1:0]       spi_rx = '0;
  logic [NREQ-1:0]     gnt, done;
  logic [DW-1:0]       rx_o, spi_tx;
  logic                busy, err, spi_ckp, spi_cph, spi_start;

  spi_mode_arbiter #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(SETUP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .mode_i(mode_i), .tx_i(tx_i),
    .gnt(gnt), .done(done), .rx_o(rx_o), .busy(busy), .err(err),
    .spi_ckp(spi_ckp), .spi_cph(spi_cph), .spi_tx(spi_tx), .spi_start(spi_start),
    .spi_done(spi_done), .spi_rx(spi_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          w;
    logic [1:0]  mode;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
    int          d;
    bit          to;
    int          grant_c;
    int          start_c;
    int          done_c;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver + transaction-level model ----------------
  int   st[NREQ];          // 0 idle, 1 waiting for grant, 2 granted
  int   ptr_m = 0;
  txn_t cur;
  bit   cur_act = 1'b0;
  int   free_at = 0;
  int   n_issued = 0;
  int   n_resets = 0;
  bit   allow_to;
  bit   quiesce;

  task automatic new_req(input int i);
    st[i] = 1;
    req[i] = 1'b1;
    mode_i[2*i +: 2] = 2'($urandom);
    tx_i[DW*i +: DW] = DW'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_immediate", {gnt, done, busy, spi_start, spi_ckp, spi_cph, spi_tx, rx_o, err}, 64'd0);
    exp_q.delete();
    cur_act = 1'b0;
    req = '0;
    for (int i = 0; i < NREQ; i++) st[i] = 0;
    ptr_m = 0;
    spi_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    free_at = cyc;
    n_resets++;
    new_req(0);
  endtask

  initial begin
    bit found;
    int w;
    int c;
`ifdef SPI_ARB_TIMEOUT_EN
    allow_to = 1'b1;
`else
    allow_to = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) st[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    free_at = cyc;
    // First transaction: requester 0, mode 00, tx A5, generator returns 3C
    new_req(0);
    mode_i[1:0] = 2'b00;
    tx_i[DW-1:0] = 8'hA5;
    while ((cyc < RUN_CYC || cur_act) && cyc < RUN_CYC + 300) begin
      c = cyc;
      quiesce = (c >= RUN_CYC);
      spi_done = 1'b0;
      if (!quiesce && cur_act && !cur.to && n_resets < 2 && c > (n_resets == 0 ? 800 : 2500)
          && c > cur.start_c && c < cur.start_c + cur.d) begin
        do_reset();
      end else begin
        if (cur_act && c == cur.done_c) begin
          st[cur.w] = 0;
          req[cur.w] = 1'b0;
          cur_act = 1'b0;
          free_at = c + 1;
          if (!quiesce && $urandom_range(0, 1) == 1) new_req(cur.w);
        end
        for (int i = 0; i < NREQ; i++) begin
          if (quiesce) begin
            if (st[i] == 1) begin st[i] = 0; req[i] = 1'b0; end
          end else if (n_issued > 0) begin
            if (st[i] == 0 && $urandom_range(0, 3) == 0) new_req(i);
            else if (st[i] == 2) begin
              if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
              if ($urandom_range(0, 3) == 0) begin
                mode_i[2*i +: 2] = 2'($urandom);
                tx_i[DW*i +: DW] = DW'($urandom);
              end
            end
          end
        end
      end
      c = cyc;
      // Arbitration: first waiting requester at or after the pointer
      if (!cur_act && c >= free_at) begin
        found = 1'b0;
        w = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && st[(ptr_m + k) % NREQ] == 1) begin
            found = 1'b1;
            w = (ptr_m + k) % NREQ;
          end
        end
        if (found) begin
          cur.w = w;
          cur.mode = mode_i[2*w +: 2];
          cur.tx = tx_i[DW*w +: DW];
          cur.to = allow_to && ($urandom_range(0, 5) == 0);
          cur.d = $urandom_range(1, 8);
          cur.rx = (n_issued == 0) ? 8'h3C : DW'($urandom);
          cur.grant_c = c + 1;
          cur.start_c = c + 1 + SETUP;
          cur.done_c = cur.start_c + (cur.to ? TMO : cur.d) + 1;
          if (cur.to) cur.rx = '1;
          exp_q.push_back(cur);
          st[w] = 2;
          ptr_m = (w + 1) % NREQ;
          cur_act = 1'b1;
          n_issued++;
        end
      end
      // Generator model: real done after d cycles, spurious pulses outside WAIT
      if (cur_act && !cur.to && c == cur.start_c + cur.d) begin
        spi_done = 1'b1;
        spi_rx = cur.rx;
      end else if (!(cur_act && c > cur.start_c && c <= cur.start_c + (cur.to ? TMO : cur.d))
                   && $urandom_range(0, 9) == 0) begin
        spi_done = 1'b1;
        spi_rx = DW'($urandom);
      end else begin
        spi_rx = DW'($urandom);
      end
      @(negedge clk);
    end
    spi_done = 1'b0;
    chk("run_bounded", cur_act, 1'b0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("activity", n_done > 30, 1'b1);
    chk("resets_applied", n_resets, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- monitor / scoreboard checker ----------------
  initial begin
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] e_done;
    logic [1:0]      e_mode;
    logic [DW-1:0]   e_tx;
    logic [DW-1:0]   e_rx;
    bit              e_err;
    bit              e_start;
    bit              in_t;
    e_mode = 2'b00; e_tx = '0; e_rx = '0; e_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        e_mode = 2'b00; e_tx = '0; e_rx = '0; e_err = 1'b0;
        chk("reset_state", {gnt, done, busy, spi_start, spi_ckp, spi_cph, spi_tx, rx_o, err}, 64'd0);
      end else begin
        in_t = 1'b0; oh = '0; e_done = '0; e_start = 1'b0;
        if (exp_q.size() > 0) begin
          if (cyc >= exp_q[0].grant_c && cyc <= exp_q[0].done_c) begin
            in_t = 1'b1;
            oh[exp_q[0].w] = 1'b1;
            if (cyc == exp_q[0].grant_c) begin
              e_mode = exp_q[0].mode;
              e_tx = exp_q[0].tx;
            end
            e_start = (cyc == exp_q[0].start_c);
            if (cyc == exp_q[0].done_c) begin
              e_done = oh;
              e_rx = exp_q[0].rx;
              if (exp_q[0].to) e_err = 1'b1;
            end
          end
        end
        chk("gnt", gnt, oh);
        chk("busy", busy, in_t);
        chk("spi_start", spi_start, e_start);
        chk("done", done, e_done);
        chk("rx_o", rx_o, e_rx);
        chk("mode", {spi_ckp, spi_cph}, e_mode);
        chk("spi_tx", spi_tx, e_tx);
        chk("err", err, e_err);
        if (e_done != '0) begin
          void'(exp_q.pop_front());
          n_done++;
        end
      end
    end
  end

endmodule
